// File: rtl/zkr_entropy_collector.sv
// zkr_entropy_collector: Zkr seed source with RCT/APT health tests and the OPST state machine.
// Optional Von Neumann debiasing of packed bits when ZKR_VON_NEUMANN_EN is defined.
module zkr_entropy_collector #(
    parameter int BIST_SAMPLES = 1024,
    parameter int RCT_CUTOFF   = 32,
    parameter int APT_WINDOW   = 512,
    parameter int APT_CUTOFF   = 410
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        raw_bit_i,
    input  logic        raw_valid_i,
    input  logic        seed_rd_i,
    output logic [31:0] seed_o,
    output logic        osc_en_o,
    output logic        fail_o
);
    localparam int BW = $clog2(BIST_SAMPLES + 1);
    localparam int WW = $clog2(APT_WINDOW);
    localparam int AW = $clog2(APT_WINDOW + 1);
    localparam logic [BW-1:0] BIST_LAST = BW'(BIST_SAMPLES - 1);
    localparam logic [5:0]    RCT_LIM   = 6'(RCT_CUTOFF);
    localparam logic [AW-1:0] APT_LIM   = AW'(APT_CUTOFF);

    typedef enum logic [1:0] {BIST = 2'b00, WAIT = 2'b01, ES16 = 2'b10, DEAD = 2'b11} opst_t;

    opst_t         state, state_n;
    logic [BW-1:0] bist_cnt, bist_n;
    logic [5:0]    rct_cnt, rct_n;
    logic          prev_bit, prev_n;
    logic [WW-1:0] apt_win, win_n;
    logic          apt_ref, ref_n;
    logic [AW-1:0] apt_cnt, apt_n;
    logic [15:0]   shreg, shreg_n;
    logic [4:0]    fill, fill_n;
    logic          hfail, vok, vbit;
`ifdef ZKR_VON_NEUMANN_EN
    logic          half, half_n, first_bit, first_n;
`endif

    always_comb begin
        state_n = state;
        bist_n  = bist_cnt;
        rct_n   = rct_cnt;
        prev_n  = prev_bit;
        win_n   = apt_win;
        ref_n   = apt_ref;
        apt_n   = apt_cnt;
        shreg_n = shreg;
        fill_n  = fill;
        hfail   = 1'b0;
        vok     = raw_valid_i;
        vbit    = raw_bit_i;
        // Health tests see every raw strobe until the source is declared dead
        if (raw_valid_i && state != DEAD) begin
            rct_n  = (raw_bit_i != prev_bit) ? 6'd1 : (rct_cnt == 6'h3f ? rct_cnt : rct_cnt + 6'd1);
            prev_n = raw_bit_i;
            win_n  = apt_win + WW'(1);
            ref_n  = (apt_win == '0) ? raw_bit_i : apt_ref;
            apt_n  = (apt_win == '0) ? AW'(1) : apt_cnt + AW'(raw_bit_i == apt_ref);
            hfail  = (rct_n == RCT_LIM) || (apt_n >= APT_LIM);
        end
`ifdef ZKR_VON_NEUMANN_EN
        half_n  = half;
        first_n = first_bit;
        vok     = 1'b0;
        if (raw_valid_i && state == WAIT) begin
            half_n  = ~half;
            first_n = raw_bit_i;
            vok     = half && (first_bit != raw_bit_i);
            vbit    = first_bit;
        end
`endif
        if (hfail)
            state_n = DEAD;
        else if (state == BIST && raw_valid_i) begin
            bist_n  = bist_cnt + BW'(1);
            state_n = (bist_cnt == BIST_LAST) ? WAIT : BIST;
        end else if (state == WAIT && vok) begin
            shreg_n = {shreg[14:0], vbit};
            fill_n  = fill + 5'd1;
            state_n = (fill == 5'd15) ? ES16 : WAIT;
        end else if (state == ES16 && seed_rd_i) begin
            state_n = WAIT;
            shreg_n = '0;
            fill_n  = '0;
        end
`ifdef ZKR_VON_NEUMANN_EN
        // A pending half-pair only survives while staying in WAIT
        if (state != WAIT || state_n != WAIT) half_n = 1'b0;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= BIST;
            bist_cnt <= '0;
            rct_cnt  <= '0;
            prev_bit <= 1'b0;
            apt_win  <= '0;
            apt_ref  <= 1'b0;
            apt_cnt  <= '0;
            shreg    <= '0;
            fill     <= '0;
            seed_o   <= '0;
            osc_en_o <= 1'b0;
            fail_o   <= 1'b0;
`ifdef ZKR_VON_NEUMANN_EN
            half      <= 1'b0;
            first_bit <= 1'b0;
`endif
        end else begin
            state    <= state_n;
            bist_cnt <= bist_n;
            rct_cnt  <= rct_n;
            prev_bit <= prev_n;
            apt_win  <= win_n;
            apt_ref  <= ref_n;
            apt_cnt  <= apt_n;
            shreg    <= shreg_n;
            fill     <= fill_n;
            seed_o   <= {state_n, 14'b0, (state_n == ES16) ? shreg_n : 16'h0};
            osc_en_o <= state_n != DEAD;
            fail_o   <= state_n == DEAD;
`ifdef ZKR_VON_NEUMANN_EN
            half      <= half_n;
            first_bit <= first_n;
`endif
        end
    end
endmodule

// File: doc/zkr_entropy_collector.md
# zkr_entropy_collector

Downstream consumer of the Zkr ring-oscillator stage. Samples the raw oscillator bit on a strobe and runs continuous health tests (repetition count and adaptive proportion). Packs accepted bits into 16-bit entropy words and presents them through the `seed` CSR view with the Zkr OPST state machine (BIST/WAIT/ES16/DEAD). Also drives the oscillator enable, so a failed source is shut down.

## Interface
- `BIST_SAMPLES`, 1024: raw samples consumed in BIST before the first WAIT.
- `RCT_CUTOFF`, 32: consecutive identical raw bits that trigger a failure.
- `APT_WINDOW`, 512: adaptive-proportion window length in raw samples (power of two).
- `APT_CUTOFF`, 410: count of the window's first bit value that triggers a failure.
- `clk` in 1: single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `raw_bit_i` in 1: oscillator output bit.
- `raw_valid_i` in 1: single-cycle strobe; `raw_bit_i` is sampled on cycles where it is high.
- `seed_rd_i` in 1: one-cycle pulse on a CSR access to `seed` (read-with-write).
- `seed_o` out 32: `{opst[1:0], 14'b0, entropy[15:0]}`.
- `osc_en_o` out 1: enable to the ring-oscillator stage.
- `fail_o` out 1: sticky health-test failure flag.

## Operation
- OPST encoding: BIST=00, WAIT=01, ES16=10, DEAD=11.
- BIST
  - Counts `BIST_SAMPLES` strobes.
  - Health tests are active; no bits are packed.
  - On reaching the count with no failure, go to WAIT.
- WAIT
  - Each accepted bit shifts into `shreg[15:0]` (LSB first in, `shreg <= {shreg[14:0], bit}`) and increments a 5-bit fill counter.
  - When the fill reaches 16, go to ES16.
- ES16
  - `seed_o[15:0] = shreg`.
  - Further strobes still feed the health tests; their bits are discarded (no second buffer).
  - `seed_rd_i` returns to WAIT, with `shreg` and fill cleared.
- DEAD
  - Entered from any state when RCT or APT fails.
  - Sticky until `rst_n`.
  - `osc_en_o = 0`, `fail_o = 1`.
- `seed_o[15:0]` is forced to 0 in every state except ES16. Bits 29:16 are always 0.
- RCT: a 6-bit run counter.
  - Resets to 1 when the bit differs from the previous raw bit; otherwise increments, saturating.
  - Fail when it reaches `RCT_CUTOFF`.
- APT
  - The first sample of each window is latched as reference; a counter counts matches, including the reference itself.
  - Fail when count ≥ `APT_CUTOFF`.
  - The window counter wraps at `APT_WINDOW` and restarts with the next sample as reference.
- Health tests always see raw samples, independent of the debiasing configuration.

## Timing
- Reset values:
  - State BIST.
  - `seed_o = 32'h0000_0000`.
  - `osc_en_o = 0`, `fail_o = 0`.
  - All counters and `shreg` = 0.
- `osc_en_o` rises at the first `clk` edge after `rst_n` deasserts.
- All outputs are registered. State and `seed_o` update at the edge that samples the causing strobe or read (1-cycle latency).
- Reading `seed_o` in the cycle `seed_rd_i` is high returns the pre-read value. OPST=WAIT is visible the following cycle.
- 16th bit and `seed_rd_i` in the same cycle while in WAIT: the read has no effect; ES16 next cycle.
- Health failure and `seed_rd_i` in the same cycle while in ES16: DEAD wins; entropy reads as 0 next cycle.
- Failure on the final BIST sample: DEAD, not WAIT.
- `rst_n` asserted mid-word: immediate return to reset values; the partial word is lost.
- `seed_rd_i` in BIST, WAIT or DEAD: ignored.

## Configuration
- `ZKR_VON_NEUMANN_EN` defined:
  - Accepted raw bits are paired (first, second).
  - 01 → pack 0; 10 → pack 1; 00/11 → discard the pair.
  - A half-pair is dropped on entering ES16 or DEAD and on read.
- Undefined: every strobe sampled in WAIT packs `raw_bit_i` directly.

## Test plan
- Reset release, alternating bit stream, 1024 strobes → OPST 00 until strobe 1024, 01 the next cycle; `osc_en_o=1` from the first edge after reset.
- In WAIT (debias off), 16 strobes of 16'hA5C3 pattern MSB-first → OPST=10, `seed_o=32'h8000_A5C3`; `seed_rd_i` → `seed_o=32'h4000_0000` next cycle.
- 32 consecutive 1s after BIST → DEAD on the 32nd, `seed_o=32'hC000_0000`, `osc_en_o=0`, `fail_o=1`; survives further strobes and reads until `rst_n`.
- APT: window of 512 with 410 zeros, max run 20 → DEAD at the 410th match; a window with 409 zeros stays healthy.
- `ZKR_VON_NEUMANN_EN`: raw pairs 01,10,11,00,10 → packs 0,1,1; fill=3.
- `rst_n` low for 1 cycle with fill=9 → BIST, `seed_o=0`, fill=0; a read in the same cycle as a failure in ES16 → DEAD.
